// File: rtl/mmio_slot_arbiter.sv
// mmio_slot_arbiter: round-robin arbiter sharing one MMIO slot between NUM_REQ requesters.
// Define MMIO_ARB_TIMEOUT_EN to add an ISSUE watchdog that forces a decode error after TIMEOUT_CYCLES.
module mmio_slot_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ-1:0]      req_write,
  input  logic [NUM_REQ*8-1:0]    req_addr,
  input  logic [NUM_REQ*32-1:0]   req_wr_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [31:0]             rsp_rd_data,
  output logic                    rsp_slave_error,
  output logic                    rsp_decode_error,
  output logic                    chip_select,
  output logic                    read,
  output logic                    write,
  output logic [7:0]              addr,
  output logic [31:0]             wr_data,
  output logic                    transaction_completed,
  input  logic [31:0]             rd_data,
  input  logic                    wr_done,
  input  logic                    rd_done,
  input  logic                    slave_error,
  input  logic                    decode_error
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  state_e         state_q;
  logic [PW-1:0]  rr_ptr_q, win_q, win_d;
  logic           wr_q, any_req, done, tmo;
  logic [7:0]     addr_q;
  logic [31:0]    wd_q, rdata_q;
  logic           serr_q, derr_q;
  int             idx;
  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("mmio_slot_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES at least 2");
  end
  // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
  always_comb begin
    win_d   = rr_ptr_q;
    any_req = 1'b0;
    idx     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        win_d   = PW'(idx);
        any_req = 1'b1;
      end
    end
  end
  assign done = wr_done | rd_done;
`ifdef MMIO_ARB_TIMEOUT_EN
  logic [15:0] wdog_q;
  assign tmo = wdog_q == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge arst)
    if (arst) wdog_q <= '0;
    else      wdog_q <= (state_q == ISSUE) ? wdog_q + 16'd1 : '0;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      win_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wd_q     <= '0;
      rdata_q  <= '0;
      serr_q   <= 1'b0;
      derr_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          win_q    <= win_d;
          wr_q     <= req_write[win_d];
          addr_q   <= req_addr[8*win_d +: 8];
          wd_q     <= req_wr_data[32*win_d +: 32];
          rr_ptr_q <= PW'((int'(win_d) + 1) % NUM_REQ);
          state_q  <= ISSUE;
        end
        ISSUE: if (done) begin
          rdata_q <= wr_q ? '0 : rd_data;
          serr_q  <= slave_error;
          derr_q  <= decode_error;
          state_q <= RESP;
        end else if (tmo) begin
          rdata_q <= '0;
          serr_q  <= 1'b0;
          derr_q  <= 1'b1;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Grant is combinational; gate with arst so it stays low while reset is held.
  assign req_ready             = (state_q == IDLE && any_req && !arst) ? NUM_REQ'(1) << win_d : '0;
  assign rsp_valid             = (state_q == RESP) ? NUM_REQ'(1) << win_q : '0;
  assign transaction_completed = state_q == RESP;
  assign chip_select           = state_q == ISSUE;
  assign read                  = (state_q == ISSUE) && !wr_q;
  assign write                 = (state_q == ISSUE) && wr_q;
  assign addr                  = (state_q == ISSUE) ? addr_q : '0;
  assign wr_data               = (state_q == ISSUE) ? wd_q : '0;
  assign rsp_rd_data           = rdata_q;
  assign rsp_slave_error       = serr_q;
  assign rsp_decode_error      = derr_q;
endmodule

// File: tb/tb_mmio_slot_arbiter.sv
// tb_mmio_slot_arbiter: directed transactions; expected responses go to a queue checked by a monitor.
module tb_mmio_slot_arbiter;
  localparam int N = 4;
  logic          clk = 1'b0, arst = 1'b1;
  logic [N-1:0]  req_valid = '0, req_write = '0;
  logic [N*8-1:0]  req_addr = '0;
  logic [N*32-1:0] req_wr_data = '0;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [31:0]   rsp_rd_data, wr_data, rd_data = '0;
  logic          rsp_slave_error, rsp_decode_error, chip_select, read, write, transaction_completed;
  logic [7:0]    addr;
  logic          wr_done = 1'b0, rd_done = 1'b0, slave_error = 1'b0, decode_error = 1'b0;
  typedef struct {int idx; logic [31:0] rd; logic se; logic de;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_pass = 0;
  mmio_slot_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .arst(arst), .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wr_data(req_wr_data), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data),
    .rsp_slave_error(rsp_slave_error), .rsp_decode_error(rsp_decode_error), .chip_select(chip_select),
    .read(read), .write(write), .addr(addr), .wr_data(wr_data),
    .transaction_completed(transaction_completed), .rd_data(rd_data), .wr_done(wr_done),
    .rd_done(rd_done), .slave_error(slave_error), .decode_error(decode_error));
  always #5 clk = ~clk;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask
  always @(negedge clk) if (!arst && rsp_valid != '0) begin
    if (q.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
    else begin
      exp_t e;
      e = q.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(1) << e.idx);
      chk("rsp_rd_data", 64'(rsp_rd_data), 64'(e.rd));
      chk("rsp_slave_error", 64'(rsp_slave_error), 64'(e.se));
      chk("rsp_decode_error", 64'(rsp_decode_error), 64'(e.de));
      chk("rsp_tc", 64'(transaction_completed), 64'd1);
    end
  end
  task automatic xact(int i, bit wr, logic [7:0] a, logic [31:0] wd, logic [31:0] rd, bit se, bit de, int lat);
    req_valid[i] = 1'b1; req_write[i] = wr; req_addr[i*8 +: 8] = a; req_wr_data[i*32 +: 32] = wd;
    #1 chk("grant", 64'(req_ready), 64'(1) << i);
    q.push_back('{i, wr ? 32'h0 : rd, se, de});
    @(negedge clk); req_valid[i] = 1'b0;
    #1 chk("issue_cs", 64'(chip_select), 64'd1);
    chk("issue_read", 64'(read), 64'(!wr));
    chk("issue_write", 64'(write), 64'(wr));
    chk("issue_addr", 64'(addr), 64'(a));
    chk("issue_wr_data", 64'(wr_data), 64'(wd));
    chk("issue_no_ready", 64'(req_ready), 64'd0);
    repeat (lat) @(negedge clk);
    rd_data = rd; slave_error = se; decode_error = de; wr_done = wr; rd_done = !wr;
    @(negedge clk);
    rd_done = 0; wr_done = 0; slave_error = 0; decode_error = 0; rd_data = 32'h5A5A_5A5A;
    #1 chk("resp_tc", 64'(transaction_completed), 64'd1);
    chk("resp_cs", 64'({chip_select, read, write}), 64'd0);
    chk("resp_addr_wd", 64'({addr, wr_data}), 64'd0);
    chk("resp_no_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
  endtask
  initial begin
    req_valid = 4'b0010;
    #3 chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_outs", 64'({rsp_valid, chip_select, read, write, addr, transaction_completed}), 64'd0);
    chk("rst_rsp", 64'({rsp_rd_data, rsp_slave_error, rsp_decode_error}), 64'd0);
    @(negedge clk); arst = 1'b0; req_valid = '0;
    @(negedge clk);
    xact(1, 1'b0, 8'h04, 32'h0, 32'h0000_00FF, 1'b0, 1'b0, 2);
    xact(2, 1'b1, 8'h00, 32'hCAFE_F00D, 32'hDEAD_BEEF, 1'b1, 1'b0, 0);
    // abort a request from requester 3 with reset while it is on the slot
    req_valid[3] = 1'b1; req_write[3] = 1'b0; req_addr[31:24] = 8'h33;
    #1 chk("abort_grant", 64'(req_ready), 64'b1000);
    @(negedge clk); req_valid[3] = 1'b0;
    #1 chk("abort_cs", 64'(chip_select), 64'd1);
    #2 arst = 1'b1; rd_done = 1'b1; rd_data = 32'h1234;
    #1 chk("abort_outs", 64'({req_ready, rsp_valid, chip_select, read, write, addr, transaction_completed}), 64'd0);
    chk("abort_wd_rsp", 64'({wr_data, rsp_slave_error, rsp_decode_error}), 64'd0);
    chk("abort_rdata", 64'(rsp_rd_data), 64'd0);
    @(negedge clk); arst = 1'b0; rd_done = 1'b0;
    @(negedge clk); #1 chk("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    @(negedge clk); #1 chk("no_rsp_after_rst2", 64'(rsp_valid | {N{chip_select}}), 64'd0);
    req_valid[3] = 1'b1;
    xact(1, 1'b0, 8'h10, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b1, 1);
    req_valid = '0;
    // fresh reset so the round robin starts from 0
    arst = 1'b1;
    @(negedge clk); arst = 1'b0;
    @(negedge clk); req_valid = 4'b1111; req_write = '0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("rr_grant", 64'(req_ready), 64'(1) << (k % 4));
      q.push_back('{k % 4, 32'h100 + k, 1'b0, 1'b0});
      @(negedge clk); #1 chk("rr_issue_ready", 64'(req_ready), 64'd0);
      rd_data = 32'h100 + k; rd_done = 1'b1;
      @(negedge clk); rd_done = 1'b0; #1 chk("rr_resp_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    req_valid = '0;
    rd_data = 32'h55; rd_done = 1'b1; wr_done = 1'b1; slave_error = 1'b1;
    @(negedge clk); rd_done = 1'b0; wr_done = 1'b0; slave_error = 1'b0;
    #1 chk("idle_done_ignored", 64'({rsp_rd_data, rsp_slave_error}), 64'({32'h104, 1'b0}));
    chk("idle_done_no_cs", 64'({chip_select, transaction_completed}), 64'd0);
    @(negedge clk);
`ifdef MMIO_ARB_TIMEOUT_EN
    begin
      int cyc;
      cyc = 0;
      req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[7:0] = 8'h20; rd_data = 32'hBAD;
      #1 chk("tmo_grant", 64'(req_ready), 64'd1);
      q.push_back('{0, 32'h0, 1'b0, 1'b1});
      @(negedge clk); req_valid[0] = 1'b0;
      while (chip_select && cyc < 40) begin cyc++; @(negedge clk); end
      chk("tmo_cycles", 64'(cyc), 64'd16);
      @(negedge clk);
      xact(0, 1'b0, 8'h20, 32'h0, 32'h0000_0ABC, 1'b0, 1'b0, 15);
    end
`endif
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mmio_slot_arbiter.md
MMIO_SLOT_ARBITER -- requirements
Module: mmio_slot_arbiter

Interface
- REQ-001: Parameter NUM_REQ, default 4. Number of requesters, range 2..8.
- REQ-002: Parameter TIMEOUT_CYCLES, default 256. ISSUE-state watchdog limit; used only when the Configuration macro is defined.
- REQ-003: clk  in  1  single clock; all state updates on the rising edge.
- REQ-004: arst  in  1  reset, asynchronous, active-high.
- REQ-005: req_valid  in  NUM_REQ  request pending, one bit per requester.
- REQ-006: req_write  in  NUM_REQ  1 = write, 0 = read, per requester.
- REQ-007: req_addr  in  NUM_REQ*8  packed slot addresses; requester i occupies bits [8i+7:8i].
- REQ-008: req_wr_data  in  NUM_REQ*32  packed write data; requester i occupies bits [32i+31:32i].
- REQ-009: req_ready  out  NUM_REQ  one-hot grant/accept pulse.
- REQ-010: rsp_valid  out  NUM_REQ  one-hot response pulse.
- REQ-011: rsp_rd_data  out  32  response read data, shared by all requesters.
- REQ-012: rsp_slave_error, rsp_decode_error  out  1 each  response error flags, shared by all requesters.
- REQ-013: Slot-side outputs: chip_select 1, read 1, write 1, addr 8, wr_data 32, transaction_completed 1.
- REQ-014: Slot-side inputs: rd_data 32, wr_done 1, rd_done 1, slave_error 1, decode_error 1.

Function
- REQ-015: The arbiter SHALL implement a three-state FSM: IDLE, ISSUE, RESP.
- REQ-016: IDLE, arbitration: with any req_valid high, select the first set bit searching round-robin upward from rr_ptr, wrapping at NUM_REQ.
- REQ-017: IDLE, grant: req_ready[winner] is high combinationally in that cycle only. At that edge:
  - latch winner, req_write, addr and wr_data;
  - set rr_ptr = (winner+1) mod NUM_REQ;
  - go to ISSUE.
- REQ-018: Requesters SHALL hold valid and payload stable until req_ready; a requester dropping valid before grant is not granted.
- REQ-019: ISSUE, slot drive:
  - chip_select = 1;
  - read = !latched write; write = latched write;
  - addr and wr_data from the latches, held stable for the whole state.
- REQ-020: ISSUE, completion: on the first cycle with wr_done or rd_done high:
  - capture rd_data into rsp_rd_data (captured as 0 for writes);
  - capture slave_error and decode_error;
  - go to RESP.
- REQ-021: RESP lasts exactly one cycle:
  - rsp_valid[winner] = 1;
  - transaction_completed = 1;
  - chip_select, read, write = 0;
  - then go to IDLE.
- REQ-022: rsp_rd_data and the error flags hold their captured values until the next capture.
- REQ-023: A new grant SHALL NOT occur in the cycle of RESP; minimum spacing between grants is 3 cycles. No back-to-back grant starvation: each pending requester is served within NUM_REQ grants.
- REQ-024: Outside ISSUE, addr and wr_data SHALL be 0.
- REQ-025: wr_done or rd_done arriving outside ISSUE SHALL be ignored.

Reset
- REQ-026: While arst is high, the following SHALL be 0:
  - FSM state (= IDLE) and rr_ptr;
  - all latches, and rsp_rd_data and both rsp error flags;
  - req_ready, rsp_valid, chip_select, read, write, addr, wr_data, transaction_completed.
- REQ-027: Reset asserted mid-transaction SHALL abort it; no rsp_valid is issued for the aborted request after reset release.
- REQ-028: The first grant after release goes to the lowest-index valid requester.

Configuration
- REQ-029: Macro MMIO_ARB_TIMEOUT_EN, defined: an 8..16-bit watchdog counter clears on ISSUE entry and increments each ISSUE cycle.
- REQ-030: With the macro defined, if count reaches TIMEOUT_CYCLES-1 without a done, the next state is RESP with rsp_decode_error=1, rsp_slave_error=0, rsp_rd_data=0. A done in the same cycle as the timeout wins (normal capture).
- REQ-031: Macro undefined: no counter exists; ISSUE waits indefinitely for a done.

Verification
- REQ-032: Single read: req 1 valid, read, addr 0x04; slot returns rd_done with rd_data 0x0000_00FF. Required:
  - req_ready[1] in the first cycle;
  - chip_select=1, read=1, addr=0x04 until done;
  - rsp_valid[1] with rsp_rd_data=0xFF and transaction_completed=1 in the same cycle.
- REQ-033: Round robin: all four requesters valid continuously, rr_ptr=0 -> grants in order 0,1,2,3,0; no req_ready during ISSUE or RESP.
- REQ-034: Error passthrough: write to addr 0x00, slot returns wr_done with slave_error=1 -> rsp_slave_error=1, rsp_decode_error=0, rsp_rd_data=0.
- REQ-035: Reset mid-ISSUE: arst pulsed while chip_select=1. Required:
  - all outputs 0 immediately;
  - no rsp_valid after release;
  - next grant goes to the lowest valid index.
- REQ-036: Timeout (macro defined, TIMEOUT_CYCLES=16): the slot never returns done -> RESP after 16 ISSUE cycles, rsp_decode_error=1, rsp_rd_data=0. Done in cycle 16 -> normal capture.
